// File: rtl/spi_slv.sv
// -----------------------------------------------------------------------------
// spi_slv -- SPI mode-0 slave (responder), MSB first.
//
// SCLK, SS_N and MOSI are oversampled on clk through a two-flop synchroniser
// plus one delay flop used for edge detection. One MOSI bit is captured per
// SCLK rising edge. MISO advances one bit per SCLK falling edge. The transmit
// word comes from a single-entry hold register that is loaded through a
// valid/ready handshake. When SS_N deasserts, the received word, its bit count
// and an overflow flag are published along with a one-cycle rx_valid.
//
// Ports:
//   clk, sresetn      system clock, synchronous active-low reset
//   SCLK, SS_N, MOSI  asynchronous SPI inputs from the master
//   MISO, MISO_OE     registered slave data out and its pad output enable
//   tx_data/valid/rdy transmit word handshake into the hold register
//   tx_udr            pulse: a transfer started while the hold register was empty
//   rx_data/len/ovf   received word (right-justified), bit count, overflow flag
//   rx_valid          pulse: rx_* outputs were just updated
//   busy              a transfer is in progress (FSM ACTIVE)
// -----------------------------------------------------------------------------
module spi_slv #(
    parameter int SPI_MAXLEN = 16,
    parameter int CLK_DIVIDE = 100
) (
    input  logic                          clk,
    input  logic                          sresetn,
    input  logic                          SCLK,
    input  logic                          SS_N,
    input  logic                          MOSI,
    output logic                          MISO,
    output logic                          MISO_OE,
    input  logic [SPI_MAXLEN-1:0]         tx_data,
    input  logic                          tx_valid,
    output logic                          tx_rdy,
    output logic                          tx_udr,
    output logic [SPI_MAXLEN-1:0]         rx_data,
    output logic [$clog2(SPI_MAXLEN):0]   rx_len,
    output logic                          rx_valid,
    output logic                          rx_ovf,
    output logic                          busy
);

    localparam int CW = $clog2(SPI_MAXLEN) + 1;

    // The oversampler needs several clk cycles per SCLK half period.
    if (CLK_DIVIDE < 8) begin : g_div_chk
        $error("spi_slv: CLK_DIVIDE must be at least 8");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Synchroniser chains: [0]=s1, [1]=s2, [2]=s3 (edge-detect delay).
    logic [2:0] sclk_sync_q, ss_sync_q, mosi_sync_q;

    state_e                state_q, state_d;
    logic [SPI_MAXLEN-1:0] hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic [SPI_MAXLEN-1:0] shift_tx_q, shift_tx_d;
    logic [SPI_MAXLEN-1:0] rx_shift_q, rx_shift_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  ovf_q, ovf_d;
    logic                  miso_q, miso_d;
    logic                  tx_udr_q, tx_udr_d;
    logic [SPI_MAXLEN-1:0] rx_data_q, rx_data_d;
    logic [CW-1:0]         rx_len_q, rx_len_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  rx_ovf_q, rx_ovf_d;
    logic                  pend_q, pend_d;

    logic                  sclk_rise, sclk_fall, ss_rise, ss_fall, mosi_s2;
    logic [SPI_MAXLEN-1:0] len_mask;

    assign sclk_rise =  sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] &  sclk_sync_q[2];
    assign ss_rise   =  ss_sync_q[1]   & ~ss_sync_q[2];
    assign ss_fall   = ~ss_sync_q[1]   &  ss_sync_q[2];
    assign mosi_s2   =  mosi_sync_q[1];

    // Keeps only the low bit_cnt bits of rx_shift; bits above that are stale
    // leftovers from an earlier, longer transfer.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < SPI_MAXLEN; i++) begin
            len_mask[i] = (CW'(i) < bit_cnt_q);
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_tx_d  = shift_tx_q;
        rx_shift_d  = rx_shift_q;
        bit_cnt_d   = bit_cnt_q;
        ovf_d       = ovf_q;
        miso_d      = miso_q;
        tx_udr_d    = 1'b0;
        rx_data_d   = rx_data_q;
        rx_len_d    = rx_len_q;
        rx_valid_d  = 1'b0;
        rx_ovf_d    = rx_ovf_q;
        pend_d      = pend_q;

        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (ss_fall || pend_q) begin
                    pend_d = 1'b0;
                    if (hold_full_q) begin
                        shift_tx_d  = hold_q;
                        hold_full_d = 1'b0;
                    end else begin
                        shift_tx_d = '0;
                        tx_udr_d   = 1'b1;
                    end
                    bit_cnt_d = '0;
                    ovf_d     = 1'b0;
                    miso_d    = shift_tx_d[SPI_MAXLEN-1];
                    state_d   = ACTIVE;
                end
            end

            ACTIVE: begin
                if (ss_rise) begin
                    // Results are registered on the way into DONE so that
                    // rx_valid and rx_data/len/ovf are visible during the DONE
                    // cycle together. SCLK edges in this cycle are dropped.
                    state_d = DONE;
                    miso_d  = 1'b0;
                    if (bit_cnt_q != '0) begin
                        rx_data_d  = rx_shift_q & len_mask;
                        rx_len_d   = bit_cnt_q;
                        rx_ovf_d   = ovf_q;
                        rx_valid_d = 1'b1;
                    end
                end else begin
                    if (sclk_rise) begin
                        rx_shift_d = {rx_shift_q[SPI_MAXLEN-2:0], mosi_s2};
                        if (bit_cnt_q == CW'(SPI_MAXLEN)) begin
                            ovf_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                    if (sclk_fall) begin
                        shift_tx_d = shift_tx_q << 1;
                        miso_d     = shift_tx_q[SPI_MAXLEN-2];
                    end
                end
            end

            DONE: begin
                miso_d  = 1'b0;
                // An SS_N fall seen here is remembered and served from IDLE.
                if (ss_fall) begin
                    pend_d = 1'b1;
                end
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                miso_d  = 1'b0;
            end
        endcase

        // A load only happens while the hold register is empty, so it never
        // collides with the hand-off above; a word arriving in the same cycle
        // as the SS_N fall waits here for the next transfer.
        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '0;
            mosi_sync_q <= '0;
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_tx_q  <= '0;
            rx_shift_q  <= '0;
            bit_cnt_q   <= '0;
            ovf_q       <= 1'b0;
            miso_q      <= 1'b0;
            tx_udr_q    <= 1'b0;
            rx_data_q   <= '0;
            rx_len_q    <= '0;
            rx_valid_q  <= 1'b0;
            rx_ovf_q    <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], SCLK};
            ss_sync_q   <= {ss_sync_q[1:0], SS_N};
            mosi_sync_q <= {mosi_sync_q[1:0], MOSI};
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_tx_q  <= shift_tx_d;
            rx_shift_q  <= rx_shift_d;
            bit_cnt_q   <= bit_cnt_d;
            ovf_q       <= ovf_d;
            miso_q      <= miso_d;
            tx_udr_q    <= tx_udr_d;
            rx_data_q   <= rx_data_d;
            rx_len_q    <= rx_len_d;
            rx_valid_q  <= rx_valid_d;
            rx_ovf_q    <= rx_ovf_d;
            pend_q      <= pend_d;
        end
    end

    assign MISO     = miso_q;
    assign MISO_OE  = (state_q == ACTIVE);
    assign busy     = (state_q == ACTIVE);
    assign tx_rdy   = ~hold_full_q;
    assign tx_udr   = tx_udr_q;
    assign rx_data  = rx_data_q;
    assign rx_len   = rx_len_q;
    assign rx_valid = rx_valid_q;
    assign rx_ovf   = rx_ovf_q;

endmodule

// File: tb/tb_spi_slv.sv
// -----------------------------------------------------------------------------
// tb_spi_slv -- randomized and directed bench for spi_slv.
// A behavioural SPI master drives the pins; expected receive results are
// queued per transfer and a separate monitor pops them on rx_valid.
// -----------------------------------------------------------------------------
module tb_spi_slv;

    localparam int N  = 16;
    localparam int CW = $clog2(N) + 1;

    logic          clk = 1'b0;
    logic          sresetn = 1'b0;
    logic          SCLK = 1'b0, SS_N = 1'b1, MOSI = 1'b0;
    logic          MISO, MISO_OE;
    logic [N-1:0]  tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_rdy, tx_udr;
    logic [N-1:0]  rx_data;
    logic [CW-1:0] rx_len;
    logic          rx_valid, rx_ovf, busy;

    spi_slv #(.SPI_MAXLEN(N), .CLK_DIVIDE(100)) dut (
        .clk(clk), .sresetn(sresetn), .SCLK(SCLK), .SS_N(SS_N), .MOSI(MOSI),
        .MISO(MISO), .MISO_OE(MISO_OE), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_rdy(tx_rdy), .tx_udr(tx_udr), .rx_data(rx_data), .rx_len(rx_len),
        .rx_valid(rx_valid), .rx_ovf(rx_ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          len;
        logic        ovf;
    } rx_t;

    rx_t         exp_q[$];
    rx_t         mon_e;
    int          checks = 0;
    int          errors = 0;
    int          udr_cnt = 0;
    bit          mdl_full = 1'b0;
    logic [15:0] mdl_hold = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: counts underrun pulses and scores every rx_valid.
    always @(negedge clk) begin
        if (tx_udr) udr_cnt++;
        if (rx_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected: got rx_valid data=%0h len=%0d, expected none",
                         rx_data, rx_len);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rx_data", 32'(rx_data), mon_e.data);
                chk("rx_len",  32'(rx_len),  32'(mon_e.len));
                chk("rx_ovf",  32'(rx_ovf),  32'(mon_e.ovf));
            end
        end
    end

    task automatic load_tx(input logic [15:0] word);
        @(negedge clk);
        chk("tx_rdy_before_load", 32'(tx_rdy), 32'(!mdl_full));
        tx_data  = word;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        if (!mdl_full) begin
            mdl_full = 1'b1;
            mdl_hold = word;
        end
        chk("tx_rdy_after_load", 32'(tx_rdy), 32'd0);
    endtask

    // One complete transfer of nbits, MSB first, SCLK half period = div/2 clks.
    task automatic xfer(input int nbits, input logic [31:0] word, input int div);
        int          half;
        int          u0;
        logic [15:0] exp_tx;
        bit          exp_udr;
        rx_t         e;
        half    = div / 2;
        exp_tx  = mdl_full ? mdl_hold : 16'h0;
        exp_udr = !mdl_full;
        mdl_full = 1'b0;
        if (nbits > 0) begin
            e.len  = (nbits > N) ? N : nbits;
            e.ovf  = (nbits > N);
            e.data = word & ((32'h1 << e.len) - 1);
            exp_q.push_back(e);
        end
        u0 = udr_cnt;
        @(negedge clk);
        SS_N = 1'b0;
        repeat (half) @(negedge clk);
        chk("miso_oe_selected", 32'(MISO_OE), 32'd1);
        chk("busy_selected", 32'(busy), 32'd1);
        chk("tx_udr_pulses", 32'(udr_cnt - u0), 32'(exp_udr));
        chk("tx_rdy_after_fall", 32'(tx_rdy), 32'd1);
        for (int i = 0; i < nbits; i++) begin
            MOSI = word[nbits-1-i];
            repeat (half) @(negedge clk);
            chk("miso_bit", 32'(MISO), (i < N) ? 32'(exp_tx[N-1-i]) : 32'd0);
            SCLK = 1'b1;
            repeat (half) @(negedge clk);
            SCLK = 1'b0;
        end
        repeat (half) @(negedge clk);
        SS_N = 1'b1;
        repeat (10) @(negedge clk);
        chk("miso_oe_released", 32'(MISO_OE), 32'd0);
        chk("miso_idle", 32'(MISO), 32'd0);
        chk("busy_released", 32'(busy), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_miso"},     32'(MISO),     32'd0);
        chk({tag, "_miso_oe"},  32'(MISO_OE),  32'd0);
        chk({tag, "_tx_rdy"},   32'(tx_rdy),   32'd1);
        chk({tag, "_tx_udr"},   32'(tx_udr),   32'd0);
        chk({tag, "_rx_data"},  32'(rx_data),  32'd0);
        chk({tag, "_rx_len"},   32'(rx_len),   32'd0);
        chk({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
        chk({tag, "_rx_ovf"},   32'(rx_ovf),   32'd0);
        chk({tag, "_busy"},     32'(busy),     32'd0);
    endtask

    initial begin
        repeat (5) @(negedge clk);
        sresetn = 1'b1;
        repeat (5) @(negedge clk);
        chk_reset_vals("reset");

        // Directed cases.
        load_tx(16'hA5C3);
        xfer(16, 32'h1234, 100);
        load_tx(16'hFF00);
        xfer(8, 32'h5A, 20);
        xfer(4, 32'hB, 20);
        xfer(18, 32'h3FFFF, 20);
        xfer(0, 32'h0, 20);

        // Reset in the middle of a transfer.
        load_tx(16'h1111);
        @(negedge clk);
        SS_N = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            MOSI = i[0];
            repeat (10) @(negedge clk);
            SCLK = 1'b1;
            repeat (10) @(negedge clk);
            SCLK = 1'b0;
        end
        repeat (5) @(negedge clk);
        sresetn = 1'b0;
        repeat (3) @(negedge clk);
        sresetn = 1'b1;
        mdl_full = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals("midreset");
        repeat (10) @(negedge clk);
        SS_N = 1'b1;
        repeat (10) @(negedge clk);
        chk("midreset_no_busy", 32'(busy), 32'd0);
        xfer(16, 32'h00FF, 20);

        // Randomized transfers.
        for (int t = 0; t < 8; t++) begin
            if ($urandom_range(0, 1) == 1) load_tx(16'($urandom));
            xfer($urandom_range(1, 18), 32'($urandom) & 32'h3FFFF,
                 16 + 4 * $urandom_range(0, 6));
        end

        repeat (20) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slv.md
Name: spi_slv

Overview:
SPI mode-0 slave (responder), MSB first, the far end of the SPI master driver. It oversamples SCLK, SS_N and MOSI on the system clock and shifts in one MOSI bit per SCLK rising edge. It drives MISO from a preloaded transmit word, one bit per SCLK falling edge. On SS_N deassertion it publishes the received word, its bit count and an overflow flag. It sits between the SPI pins and a register or command block on the system clock.

Parameters:
SPI_MAXLEN, 16, maximum bits per transfer (width of the tx and rx words)
CLK_DIVIDE, 100, expected clk/SCLK ratio; documentation only; must be ≥ 8

Ports:
clk  in  1  system clock
sresetn  in  1  reset, synchronous to clk, active low
SCLK  in  1  SPI clock from master, asynchronous
SS_N  in  1  slave select from master, active low, asynchronous
MOSI  in  1  master-out data, asynchronous
MISO  out  1  slave-out data
MISO_OE  out  1  MISO output enable (pad tristate control)
tx_data  in  SPI_MAXLEN  word to return on the next transfer, MSB first
tx_valid  in  1  tx_data valid
tx_rdy  out  1  holding register empty
tx_udr  out  1  one-cycle pulse: transfer started with no word loaded
rx_data  out  SPI_MAXLEN  received bits, right-justified (last bit in bit 0)
rx_len  out  $clog2(SPI_MAXLEN)+1  number of valid bits in rx_data
rx_valid  out  1  one-cycle pulse: rx_data, rx_len and rx_ovf updated
rx_ovf  out  1  more than SPI_MAXLEN bits were clocked in the last transfer
busy  out  1  FSM is ACTIVE

Behaviour:
- Sync: SCLK, SS_N and MOSI each pass through 2 flops (s1, s2) plus an s3 delay flop. Edges are detected as s2 != s3.
- Sync reset values: SCLK chain 0, MOSI chain 0, SS_N chain 0. With SS_N chain at 0, a high SS_N at reset exit yields only a rise, which IDLE ignores.
- Reset values: MISO 0, MISO_OE 0, tx_rdy 1, tx_udr 0, rx_data 0, rx_len 0, rx_valid 0, rx_ovf 0, busy 0, FSM IDLE, hold register empty.
- Reset mid-transfer: the transfer is abandoned with no rx_valid. A new transfer starts only on a later synchronized SS_N fall.
- tx handshake: the hold register loads tx_data when tx_valid && tx_rdy; tx_rdy then drops next cycle. Loads are legal in any FSM state.
- FSM IDLE:
  - On SS_N fall: shift_tx <= hold (or all zeros if empty; pulse tx_udr).
  - Hold is marked empty and tx_rdy rises the next cycle.
  - bit_cnt <= 0, ovf <= 0, MISO <= shift_tx MSB, go ACTIVE.
  - If tx_valid && tx_rdy in the same cycle as the fall, the old hold contents, or zeros if empty, are used. The new word stays in hold for the following transfer.
- FSM ACTIVE:
  - SCLK rise: rx_shift <= {rx_shift[SPI_MAXLEN-2:0], MOSI_s2}. If bit_cnt == SPI_MAXLEN, set ovf and hold bit_cnt; else bit_cnt++.
  - SCLK fall: shift_tx <= shift_tx << 1 (zero fill), MISO <= next MSB. After SPI_MAXLEN bits MISO is 0.
  - SS_N rise: go DONE. SCLK edges detected in the same cycle as the SS_N rise are ignored.
- FSM DONE (1 cycle):
  - If bit_cnt > 0: rx_data <= rx_shift masked to bit_cnt bits, rx_len <= bit_cnt, rx_ovf <= ovf, rx_valid = 1.
  - If bit_cnt == 0: no rx_valid and outputs are unchanged.
  - Always go IDLE.
- Latency: rx_valid is high in the cycle after the 3rd clk edge counting from the edge that first samples SS_N = 1 (2 sync + 1 edge register).
- MISO_OE = 1 exactly while the FSM is ACTIVE. MISO is registered and returns to 0 in IDLE.
- A new SS_N fall during DONE is deferred: its edge is not lost, and IDLE acts on it next cycle.

Test Plan:
- Load tx_data=0xA5C3; 16-bit transfer, master sends 0x1234 with CLK_DIVIDE=100 -> MISO bits 1010010111000011; rx_valid one pulse with rx_data=0x1234, rx_len=16, rx_ovf=0; tx_rdy returns to 1 after SS_N fall.
- 8-bit transfer sending 0x5A, hold loaded with 0xFF00 -> MISO shows 0xFF's eight 1s; rx_data=0x005A, rx_len=8.
- No tx word loaded; 4-bit transfer sending 0xB -> tx_udr one pulse at SS_N fall, MISO all 0; rx_data=0x000B, rx_len=4.
- 18 SCLK pulses with MOSI pattern 0x3FFFF then SS_N high -> rx_len=16, rx_ovf=1, rx_data=0xFFFF.
- SS_N low then high with zero SCLK pulses -> no rx_valid; MISO_OE pulses high for the select window only.
- sresetn asserted after 5 bits of a 16-bit transfer, released with SS_N still low -> no rx_valid; all outputs at reset values; next full transfer of 0x00FF returns rx_data=0x00FF, rx_len=16.
